// File: rtl/rvm_mem_arbiter_pkg.sv
// Shared types and constants for the rvm_mem_arbiter memory-bus arbiter slice.
// FSM state codes, arbitration mode codes and the one-hot owner encoding.
package rvm_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RVM_ARB_IDLE   = 2'd0,
        RVM_ARB_ACCESS = 2'd1,
        RVM_ARB_RESP   = 2'd2
    } arb_state_e;

    localparam int RVM_ARB_MODE_FIXED = 0;
    localparam int RVM_ARB_MODE_RR    = 1;

    // One-hot {data, fetch}; the picker grant uses the same encoding.
    typedef enum logic [1:0] {
        RVM_ARB_OWN_NONE = 2'b00,
        RVM_ARB_OWN_F    = 2'b01,
        RVM_ARB_OWN_D    = 2'b10
    } arb_owner_e;

    localparam logic [3:0] RVM_ARB_FETCH_B_EN = 4'b1111;

endpackage

// File: rtl/rvm_arb_pick2.sv
// Two-way request picker: fixed priority (data wins) or round-robin
// (previous owner loses a tie). Produces a one-hot grant.
module rvm_arb_pick2
    import rvm_mem_arbiter_pkg::*;
#(
    parameter int ARB_MODE = RVM_ARB_MODE_FIXED
) (
    input  logic       i_f_req,
    input  logic       i_d_req,
    input  arb_owner_e i_last_owner,
    output arb_owner_e o_grant
);

    always_comb begin
        // NOTE: default assignment first so no path leaves o_grant unassigned (no latch).
        o_grant = RVM_ARB_OWN_NONE;
        if (i_f_req && i_d_req) begin
            if (ARB_MODE == RVM_ARB_MODE_RR && i_last_owner == RVM_ARB_OWN_D) begin
                o_grant = RVM_ARB_OWN_F;
            end else begin
                o_grant = RVM_ARB_OWN_D;
            end
        end else if (i_d_req) begin
            o_grant = RVM_ARB_OWN_D;
        end else if (i_f_req) begin
            o_grant = RVM_ARB_OWN_F;
        end
    end

endmodule

// File: rtl/rvm_mem_arbiter.sv
// Shared memory-bus arbiter/sequencer for fetch and load/store ports.
// Optional stall timeout is enabled by defining RVM_MEM_ARB_TIMEOUT_EN.
module rvm_mem_arbiter
    import rvm_mem_arbiter_pkg::*;
#(
    parameter int ARB_MODE       = RVM_ARB_MODE_FIXED,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_done,
    output logic [31:0] f_rdata,
    output logic        f_error,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_b_en,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_c_en,
    output logic        mem_w_en,
    output logic [3:0]  mem_b_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    input  logic        mem_stall
);

    arb_state_e  r_state;
    arb_owner_e  r_owner;
    arb_owner_e  r_last_owner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_c_en;
    logic        r_w_en;
    logic [3:0]  r_b_en;
    logic        r_f_done;
    logic [31:0] r_f_rdata;
    logic        r_f_error;
    logic        r_d_done;
    logic [31:0] r_d_rdata;
    logic        r_d_error;

    arb_owner_e  w_grant;
    logic        w_timeout;
    logic [31:0] w_cap_rdata;
    logic        w_cap_error;

    rvm_arb_pick2 #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .i_f_req      (f_req),
        .i_d_req      (d_req),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant)
    );

`ifdef RVM_MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_stall_cnt;

    // Fires on the stall cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == RVM_ARB_ACCESS) && mem_stall &&
                       (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (r_state != RVM_ARB_ACCESS) begin
            r_stall_cnt <= '0;
        end else if (mem_stall) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_cap_rdata = w_timeout ? 32'd0 : mem_rdata;
    assign w_cap_error = w_timeout | mem_error;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= RVM_ARB_IDLE;
            r_owner      <= RVM_ARB_OWN_NONE;
            r_last_owner <= RVM_ARB_OWN_F;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_c_en       <= 1'b0;
            r_w_en       <= 1'b0;
            r_b_en       <= '0;
            r_f_done     <= 1'b0;
            r_f_rdata    <= '0;
            r_f_error    <= 1'b0;
            r_d_done     <= 1'b0;
            r_d_rdata    <= '0;
            r_d_error    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make done a single-cycle pulse; later assignments win.
            r_f_done <= 1'b0;
            r_d_done <= 1'b0;
            unique case (r_state)
                RVM_ARB_IDLE: begin
                    if (w_grant != RVM_ARB_OWN_NONE) begin
                        r_owner <= w_grant;
                        r_c_en  <= 1'b1;
                        r_state <= RVM_ARB_ACCESS;
                        if (w_grant == RVM_ARB_OWN_D) begin
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_w_en  <= d_wen;
                            r_b_en  <= d_b_en;
                        end else begin
                            r_addr  <= f_addr;
                            r_wdata <= '0;
                            r_w_en  <= 1'b0;
                            r_b_en  <= RVM_ARB_FETCH_B_EN;
                        end
                    end
                end
                RVM_ARB_ACCESS: begin
                    if (!mem_stall || w_timeout) begin
                        r_c_en  <= 1'b0;
                        r_state <= RVM_ARB_RESP;
                        if (r_owner == RVM_ARB_OWN_D) begin
                            r_d_rdata <= w_cap_rdata;
                            r_d_error <= w_cap_error;
                            r_d_done  <= 1'b1;
                        end else begin
                            r_f_rdata <= w_cap_rdata;
                            r_f_error <= w_cap_error;
                            r_f_done  <= 1'b1;
                        end
                    end
                end
                RVM_ARB_RESP: begin
                    r_last_owner <= r_owner;
                    r_owner      <= RVM_ARB_OWN_NONE;
                    r_state      <= RVM_ARB_IDLE;
                end
                default: r_state <= RVM_ARB_IDLE;
            endcase
        end
    end

    assign f_done    = r_f_done;
    assign f_rdata   = r_f_rdata;
    assign f_error   = r_f_error;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign d_error   = r_d_error;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_c_en  = r_c_en;
    assign mem_w_en  = r_w_en;
    assign mem_b_en  = r_b_en;

endmodule
